// File: rtl/cu_param_pkg.sv
// Shared state type, opcode map, encodings and control-word type for cu_param.
// Sits alongside mycpu_pkg; only control-unit items live here.
package cu_param_pkg;

  // Control-unit states
  typedef enum logic [2:0] {
    ST_RST  = 3'd0,
    ST_INF  = 3'd1,
    ST_EX0  = 3'd2,
    ST_MEMW = 3'd3,
    ST_SHF  = 3'd4,
    ST_HLT  = 3'd5
  } cu_state_e;

  // Opcode map (7-bit opcodes; 0x00..0x0F are register ALU ops)
  localparam logic [6:0] OP_ALU_LAST = 7'h0F;
  localparam logic [6:0] OP_LDI      = 7'h10;
  localparam logic [6:0] OP_ADI      = 7'h11;
  localparam logic [6:0] OP_LD       = 7'h20;
  localparam logic [6:0] OP_ST       = 7'h21;
  localparam logic [6:0] OP_IOR      = 7'h22;
  localparam logic [6:0] OP_IOW      = 7'h23;
  localparam logic [6:0] OP_BRZ      = 7'h30;
  localparam logic [6:0] OP_BRN      = 7'h31;
  localparam logic [6:0] OP_JMP      = 7'h32;
  localparam logic [6:0] OP_SHLN     = 7'h38;
  localparam logic [6:0] OP_HAL      = 7'h7F;

  // PC select encodings
  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_BR   = 2'b10;
  localparam logic [1:0] PS_JMP  = 2'b11;

  // Result mux encodings
  localparam logic [1:0] MD_ALU = 2'b00;
  localparam logic [1:0] MD_MEM = 2'b01;

  // ALU function selects used directly by the control unit
  localparam logic [3:0] FS_SHL  = 4'b1110;
  localparam logic [3:0] FS_MOVB = 4'b1100;
  localparam logic [3:0] FS_ADD  = 4'b0010;

  // Fixed-width part of the control word; rs and fs are sized by the
  // instantiating module's parameters and are handled there.
  typedef struct packed {
    logic       il;
    logic [1:0] ps;
    logic       rw;
    logic       mm;
    logic [1:0] md;
    logic       mb;
    logic       wen;     // active-low
    logic       iom;
    logic       req;
    logic       halted;
    logic       ill;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_IDLE = '{
    il:     1'b0,
    ps:     PS_HOLD,
    rw:     1'b0,
    mm:     1'b0,
    md:     MD_ALU,
    mb:     1'b0,
    wen:    1'b1,
    iom:    1'b0,
    req:    1'b0,
    halted: 1'b0,
    ill:    1'b0
  };

  // Control word for a memory/IO transfer cycle. The write-back and PC
  // advance only happen in the cycle the transfer completes.
  function automatic ctrl_word_t xfer_word(input logic is_load,
                                           input logic is_io,
                                           input logic is_store,
                                           input logic done);
    ctrl_word_t w;
    w     = CTRL_IDLE;
    w.req = 1'b1;
    w.iom = is_io;
    w.md  = is_load ? MD_MEM : MD_ALU;
    w.wen = ~is_store;
    w.rw  = done & is_load;
    w.ps  = done ? PS_INC : PS_HOLD;
    return w;
  endfunction

endpackage

// File: rtl/cu_param.sv
// cu_param: parametrised multicycle control unit for the mycpu datapath.
// Fetch (INF) / execute (EX0) sequencing with memory wait states, an
// N-cycle shift loop, halt/resume and an illegal-opcode pulse.
// Outputs are a combinational decode of state, instruction and flags.
// IW is expected to equal OPW + 3*RAW.
module cu_param
  import cu_param_pkg::*;
#(
  parameter int IW  = 16,
  parameter int OPW = 7,
  parameter int RAW = 3,
  parameter int FSW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IW-1:0]        ins_in,
  input  logic                 z_in,
  input  logic                 n_in,
  input  logic                 rdy_in,
  input  logic                 go_in,
  output logic                 il_out,
  output logic [1:0]           ps_out,
  output logic                 rw_out,
  output logic [3*(RAW+1)-1:0] rs_out,
  output logic                 mm_out,
  output logic [1:0]           md_out,
  output logic                 mb_out,
  output logic [FSW-1:0]       fs_out,
  output logic                 wen_out,
  output logic                 iom_out,
  output logic                 req_out,
  output logic                 halted_out,
  output logic                 ill_out
);

  localparam int RSW = 3*(RAW+1);

  // State and shift counter
  cu_state_e      state_q, state_d;
  logic [RAW-1:0] cnt_q, cnt_d;

  // Instruction fields
  logic [OPW-1:0] op;
  logic [RAW-1:0] dst_f, a_f, b_f;

  assign op    = ins_in[IW-1 -: OPW];
  assign dst_f = ins_in[3*RAW-1 -: RAW];
  assign a_f   = ins_in[2*RAW-1 -: RAW];
  assign b_f   = ins_in[RAW-1:0];

  // Register-select words: normal operand order, and the shift form that
  // reads and writes dst with srcB forced to r0.
  logic [RSW-1:0] rs_fields, rs_shift;

  assign rs_fields = {1'b0, dst_f, 1'b0, a_f, 1'b0, b_f};
  assign rs_shift  = {1'b0, dst_f, 1'b0, dst_f, 1'b0, {RAW{1'b0}}};

  // Opcode classification
  logic is_alu, is_ldi, is_adi, is_ld, is_st, is_ior, is_iow;
  logic is_brz, is_brn, is_jmp, is_shln, is_hal;
  logic is_xfer, is_load, is_io, is_store;

  assign is_alu  = (op <= OPW'(OP_ALU_LAST));
  assign is_ldi  = (op == OPW'(OP_LDI));
  assign is_adi  = (op == OPW'(OP_ADI));
  assign is_ld   = (op == OPW'(OP_LD));
  assign is_st   = (op == OPW'(OP_ST));
  assign is_ior  = (op == OPW'(OP_IOR));
  assign is_iow  = (op == OPW'(OP_IOW));
  assign is_brz  = (op == OPW'(OP_BRZ));
  assign is_brn  = (op == OPW'(OP_BRN));
  assign is_jmp  = (op == OPW'(OP_JMP));
  assign is_shln = (op == OPW'(OP_SHLN));
  assign is_hal  = (op == OPW'(OP_HAL));

  assign is_xfer  = is_ld | is_st | is_ior | is_iow;
  assign is_load  = is_ld | is_ior;
  assign is_io    = is_ior | is_iow;
  assign is_store = is_st | is_iow;

  // Decoded control word for the current cycle
  ctrl_word_t     cw;
  logic [RSW-1:0] rs_val;
  logic [FSW-1:0] fs_val;

  // Advance state and shift counter; reset aborts any wait or shift loop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Decode control word and next state from state, instruction and flags
  always_comb begin
    cw      = CTRL_IDLE;
    rs_val  = '0;
    fs_val  = '0;
    state_d = state_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_RST: begin
        state_d = ST_INF;
      end

      ST_INF: begin
        cw.il   = 1'b1;
        cw.mm   = 1'b1;
        state_d = ST_EX0;
      end

      ST_EX0: begin
        rs_val  = rs_fields;
        cw.ps   = PS_INC;
        state_d = ST_INF;
        if (is_alu) begin
          cw.rw  = 1'b1;
          fs_val = FSW'(op[3:0]);
        end else if (is_ldi) begin
          cw.rw  = 1'b1;
          cw.mb  = 1'b1;
          fs_val = FSW'(FS_MOVB);
        end else if (is_adi) begin
          cw.rw  = 1'b1;
          cw.mb  = 1'b1;
          fs_val = FSW'(FS_ADD);
        end else if (is_xfer) begin
          cw = xfer_word(is_load, is_io, is_store, rdy_in);
          if (!rdy_in) begin
            state_d = ST_MEMW;
          end
        end else if (is_brz) begin
          cw.ps = z_in ? PS_BR : PS_INC;
        end else if (is_brn) begin
          cw.ps = n_in ? PS_BR : PS_INC;
        end else if (is_jmp) begin
          cw.ps = PS_JMP;
        end else if (is_shln) begin
          // A zero shift count degenerates to a plain PC increment
          if (b_f != '0) begin
            cw.rw  = 1'b1;
            rs_val = rs_shift;
            fs_val = FSW'(FS_SHL);
            cnt_d  = b_f - RAW'(1);
            if (b_f != RAW'(1)) begin
              cw.ps   = PS_HOLD;
              state_d = ST_SHF;
            end
          end
        end else if (is_hal) begin
          state_d = ST_HLT;
        end else begin
          cw.ill = 1'b1;
        end
      end

      ST_MEMW: begin
        // Only transfer opcodes can reach this state
        rs_val = rs_fields;
        cw     = xfer_word(is_load, is_io, is_store, rdy_in);
        if (rdy_in) begin
          state_d = ST_INF;
        end
      end

      ST_SHF: begin
        // cnt_q holds the number of shift cycles still to run
        cw.rw  = 1'b1;
        rs_val = rs_shift;
        fs_val = FSW'(FS_SHL);
        cnt_d  = cnt_q - RAW'(1);
        if (cnt_q == RAW'(1)) begin
          cw.ps   = PS_INC;
          state_d = ST_INF;
        end
      end

      ST_HLT: begin
        // PC was advanced in EX0, so resume goes straight to fetch
        cw.halted = 1'b1;
        if (go_in) begin
          state_d = ST_INF;
        end
      end

      default: begin
        state_d = ST_RST;
      end
    endcase
  end

  assign il_out     = cw.il;
  assign ps_out     = cw.ps;
  assign rw_out     = cw.rw;
  assign rs_out     = rs_val;
  assign mm_out     = cw.mm;
  assign md_out     = cw.md;
  assign mb_out     = cw.mb;
  assign fs_out     = fs_val;
  assign wen_out    = cw.wen;
  assign iom_out    = cw.iom;
  assign req_out    = cw.req;
  assign halted_out = cw.halted;
  assign ill_out    = cw.ill;

endmodule

// File: tb/tb_cu_param.sv
// Self-checking bench for cu_param (IW=16). The stimulus side expands each
// instruction into its expected per-cycle control words from the opcode
// table and queues them; a negedge monitor pops and compares every cycle.
module tb_cu_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ins_in;
  logic        z_in, n_in, rdy_in, go_in;
  logic        il_out, rw_out, mm_out, mb_out, wen_out, iom_out;
  logic        req_out, halted_out, ill_out;
  logic [1:0]  ps_out, md_out;
  logic [11:0] rs_out;
  logic [3:0]  fs_out;

  typedef struct packed {
    logic       il;
    logic [1:0] ps;
    logic       rw;
    logic [11:0] rs;
    logic       mm;
    logic [1:0] md;
    logic       mb;
    logic [3:0] fs;
    logic       wen;
    logic       iom;
    logic       req;
    logic       halted;
    logic       ill;
  } word_t;

  word_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  cu_param #(.IW(16), .OPW(7), .RAW(3), .FSW(4)) dut (
    .clk(clk), .rst_n(rst_n), .ins_in(ins_in),
    .z_in(z_in), .n_in(n_in), .rdy_in(rdy_in), .go_in(go_in),
    .il_out(il_out), .ps_out(ps_out), .rw_out(rw_out), .rs_out(rs_out),
    .mm_out(mm_out), .md_out(md_out), .mb_out(mb_out), .fs_out(fs_out),
    .wen_out(wen_out), .iom_out(iom_out), .req_out(req_out),
    .halted_out(halted_out), .ill_out(ill_out)
  );

  always #5 clk = ~clk;

  word_t got;
  assign got = {il_out, ps_out, rw_out, rs_out, mm_out, md_out, mb_out,
                fs_out, wen_out, iom_out, req_out, halted_out, ill_out};

  // Monitor: one expected word per cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      word_t e;
      e = exp_q.pop_front();
      checks++;
      if (got !== e)begin
        errors++;
        $display("FAIL ctrl_word t=%0t ins=%h got=%h exp=%h", $time, ins_in, got, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic word_t idle_w();
    word_t w;
    w = '0;
    w.wen = 1'b1;
    return w;
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return (op <= 7'h0F) || op == 7'h10 || op == 7'h11 ||
           (op >= 7'h20 && op <= 7'h23) || (op >= 7'h30 && op <= 7'h32) ||
           op == 7'h38 || op == 7'h7F;
  endfunction

  task automatic step(input word_t e);
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  // Inputs that must be ignored in most states are randomised every cycle
  task automatic bg();
    rdy_in = 1'($urandom);
    go_in  = 1'($urandom);
    z_in   = 1'($urandom);
    n_in   = 1'($urandom);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bg();
    step(idle_w());
    bg();
    step(idle_w());
    rst_n = 1'b1;
    bg();
    step(idle_w());       // RST state after release
  endtask

  // Expected behaviour of one instruction: fetch, then its execute cycles
  task automatic run_instr(input logic [15:0] ins, input int waits, input int haltc,
                           input logic zv, input logic nv, input int abort_at);
    logic [6:0] op;
    logic [2:0] dst, a, k;
    word_t w, base;
    int ncyc;
    op = ins[15:9]; dst = ins[8:6]; a = ins[5:3]; k = ins[2:0];
    ncyc = 1;
    bg();
    ins_in = ins;
    w = idle_w(); w.il = 1'b1; w.mm = 1'b1;
    step(w);
    base = idle_w();
    base.rs = {1'b0, dst, 1'b0, a, 1'b0, k};
    base.ps = 2'b01;
    bg();
    if (op <= 7'h0F) begin
      w = base; w.rw = 1'b1; w.fs = op[3:0];
      step(w); ncyc++;
    end else if (op == 7'h10 || op == 7'h11) begin
      w = base; w.rw = 1'b1; w.mb = 1'b1;
      w.fs = (op == 7'h10) ? 4'b1100 : 4'b0010;
      step(w); ncyc++;
    end else if (op >= 7'h20 && op <= 7'h23) begin
      bit load, io, store;
      load  = (op == 7'h20) || (op == 7'h22);
      store = (op == 7'h21) || (op == 7'h23);
      io    = (op == 7'h22) || (op == 7'h23);
      for (int i = 0; i <= waits; i++) begin
        if (i > 0) bg();
        rdy_in = (i == waits);
        w = base;
        w.req = 1'b1; w.iom = io; w.md = load ? 2'b01 : 2'b00; w.wen = !store;
        w.rw = (i == waits) && load;
        w.ps = (i == waits) ? 2'b01 : 2'b00;
        step(w); ncyc++;
      end
    end else if (op == 7'h30 || op == 7'h31) begin
      z_in = zv; n_in = nv;
      w = base;
      w.ps = ((op == 7'h30) ? zv : nv) ? 2'b10 : 2'b01;
      step(w); ncyc++;
    end else if (op == 7'h32) begin
      w = base; w.ps = 2'b11;
      step(w); ncyc++;
    end else if (op == 7'h38) begin
      if (k == 3'd0) begin
        step(base); ncyc++;
      end else begin
        for (int i = 1; i <= int'(k); i++) begin
          if (i > 1) bg();
          if (i == abort_at) begin
            $display("instr %h op=%h aborted by reset at shift %0d", ins, op, i);
            apply_reset();
            return;
          end
          w = base; w.rw = 1'b1; w.fs = 4'b1110;
          w.rs = {1'b0, dst, 1'b0, dst, 4'b0000};
          w.ps = (i == int'(k)) ? 2'b01 : 2'b00;
          step(w); ncyc++;
        end
      end
    end else if (op == 7'h7F) begin
      step(base); ncyc++;
      for (int h = 0; h < haltc; h++) begin
        bg(); go_in = 1'b0;
        w = idle_w(); w.halted = 1'b1;
        step(w); ncyc++;
      end
      bg(); go_in = 1'b1;
      w = idle_w(); w.halted = 1'b1;
      step(w); ncyc++;
    end else begin
      w = base; w.ill = 1'b1;
      step(w); ncyc++;
    end
    $display("instr %h op=%h cycles=%0d", ins, op, ncyc);
  endtask

  initial begin
    logic [15:0] ins;
    logic [6:0]  op;
    rst_n = 1'b0; ins_in = '0; z_in = 1'b0; n_in = 1'b0;
    rdy_in = 1'b0; go_in = 1'b0;
    @(posedge clk); #1;
    apply_reset();

    // Directed cases
    run_instr(16'h0453, 0, 0, 0, 0, 0);                       // ADD r1,r2,r3
    run_instr({7'h20, 3'd4, 3'd1, 3'd2}, 3, 0, 0, 0, 0);      // LD, 3 waits
    run_instr({7'h21, 3'd5, 3'd6, 3'd7}, 3, 0, 0, 0, 0);      // ST, 3 waits
    run_instr({7'h22, 3'd1, 3'd0, 3'd0}, 0, 0, 0, 0, 0);      // IOR, no wait
    run_instr({7'h23, 3'd2, 3'd3, 3'd0}, 2, 0, 0, 0, 0);      // IOW, 2 waits
    run_instr({7'h38, 3'd2, 3'd0, 3'd5}, 0, 0, 0, 0, 0);      // SHLN k=5
    run_instr({7'h38, 3'd3, 3'd1, 3'd0}, 0, 0, 0, 0, 0);      // SHLN k=0
    run_instr({7'h38, 3'd6, 3'd0, 3'd1}, 0, 0, 0, 0, 0);      // SHLN k=1
    run_instr({7'h38, 3'd7, 3'd0, 3'd7}, 0, 0, 0, 0, 0);      // SHLN k=7
    run_instr({7'h38, 3'd2, 3'd0, 3'd5}, 0, 0, 0, 0, 3);      // reset in 3rd shift
    run_instr({7'h31, 9'h055}, 0, 0, 1'b0, 1'b1, 0);          // BRN n=1 z=0
    run_instr({7'h30, 9'h055}, 0, 0, 1'b0, 1'b1, 0);          // BRZ n=1 z=0
    run_instr({7'h30, 9'h011}, 0, 0, 1'b1, 1'b0, 0);          // BRZ taken
    run_instr({7'h32, 9'h1A2}, 0, 0, 0, 0, 0);                // JMP
    run_instr({7'h7F, 9'h000}, 0, 10, 0, 0, 0);               // HAL, 10 halt cycles
    run_instr({7'h5F, 9'h0C3}, 0, 0, 0, 0, 0);                // illegal
    run_instr({7'h10, 3'd1, 3'd0, 3'd4}, 0, 0, 0, 0, 0);      // LDI
    run_instr({7'h11, 3'd2, 3'd2, 3'd6}, 0, 0, 0, 0, 0);      // ADI

    // Randomised instruction stream
    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      case (kind)
        0, 9: op = 7'($urandom_range(0, 15));
        1:    op = 7'h10;
        2:    op = 7'h11;
        3:    op = 7'(7'h20 + $urandom_range(0, 3));
        4:    op = 7'(7'h30 + $urandom_range(0, 1));
        5:    op = 7'h32;
        6:    op = 7'h38;
        7:    op = 7'h7F;
        default: begin
          op = 7'($urandom_range(0, 127));
          while (is_legal(op)) op = 7'($urandom_range(0, 127));
        end
      endcase
      ins = {op, 9'($urandom)};
      run_instr(ins, int'($urandom_range(0, 4)), int'($urandom_range(0, 5)),
                1'($urandom), 1'($urandom),
                ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 7)) : 0);
    end

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain leftover=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cu_param.md
Name: cu_param

Overview:
- Parametrised multicycle control unit for the mycpu datapath.
- Decodes `{opcode, dst, srcA, srcB}` instructions and drives the datapath control word: PC select, IR load, register file, memory/IO, ALU function.
- New behaviour:
  - memory/IO ready handshake with wait states;
  - multi-cycle N-bit shift loop;
  - BRN on the N flag;
  - halt with resume;
  - illegal-opcode flag.

Parameters:
- IW, 16, instruction width; must equal OPW+3*RAW.
- OPW, 7, opcode width.
- RAW, 3, register address width.
- FSW, 4, ALU function-select width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- ins_in  in  IW  instruction register contents
- z_in  in  1  ALU zero flag
- n_in  in  1  ALU negative flag
- rdy_in  in  1  memory/IO ready
- go_in  in  1  resume from halt
- il_out  out  1  IR load
- ps_out  out  2  PC select: 00 hold, 01 inc, 10 branch, 11 jump
- rw_out  out  1  register write
- rs_out  out  3*(RAW+1)  {0,dst,0,srcA,0,srcB}
- mm_out  out  1  address mux: 1 = PC
- md_out  out  2  result mux: 00 ALU, 01 memory/IO
- mb_out  out  1  B mux: 1 = immediate
- fs_out  out  FSW  ALU function
- wen_out  out  1  write enable, active-low
- iom_out  out  1  1 = IO space
- req_out  out  1  memory/IO transfer request
- halted_out  out  1  in HLT state
- ill_out  out  1  illegal opcode, 1-cycle pulse

Behaviour:
- Outputs are combinational from state, ins_in and flags.
- IDLE word: ps=00, il=0, rw=0, rs=0, mm=0, md=00, mb=0, fs=0, wen=1, iom=0, req=0, halted=0, ill=0.
- Reset: state=RST, cnt_r=0; all outputs hold the IDLE word. Asserting rst_n mid-operation aborts any wait or shift loop immediately.
- Fields:
  - op = ins_in[IW-1 -: OPW]
  - dst = [3RAW-1 -: RAW]
  - a = [2RAW-1 -: RAW]
  - b = [RAW-1:0]
  - rs_out = {1'b0,dst,1'b0,a,1'b0,b} unless stated otherwise.
- States: RST, INF, EX0, MEMW, SHF, HLT.
- RST: IDLE; next INF.
- INF: IDLE plus il=1, mm=1; next EX0.
- EX0, by opcode; ns=INF and ps=01 unless stated:
  - 0x00–0x0F ALU: rw=1, fs=op[3:0].
  - 0x10 LDI: rw=1, mb=1, fs=1100.
  - 0x11 ADI: rw=1, mb=1, fs=0010.
  - 0x20 LD, 0x21 ST, 0x22 IOR, 0x23 IOW:
    - req=1; iom=1 for IOR/IOW; md=01 for LD/IOR; wen=0 for ST/IOW.
    - If rdy_in=1: rw=1 for LD/IOR, ps=01, ns=INF.
    - Else: rw=0, ps=00, ns=MEMW.
  - 0x30 BRZ: ps = z_in ? 10 : 01.
  - 0x31 BRN: ps = n_in ? 10 : 01. rw=0 for both branches.
  - 0x32 JMP: ps=11.
  - 0x38 SHLN (k = b, unsigned):
    - k=0: no-op.
    - k≥1: rw=1, rs={0,dst,0,dst,0,000}, fs=1110, cnt_r<=k-1.
    - k=1: ps=01, ns=INF. Else ps=00, ns=SHF.
  - 0x7F HAL: ps=01, ns=HLT.
  - Any other opcode: ill=1, no-op (ps=01, ns=INF).
- MEMW: holds the EX0 transfer outputs with ps=00, rw=0.
  - On rdy_in=1: rw=1 for loads, ps=01, ns=INF.
  - No timeout; waits indefinitely.
- SHF: same shift word as EX0 SHLN; cnt_r decrements each cycle.
  - When cnt_r==1: ps=01, ns=INF. Else ps=00, stay.
  - Total shift cycles = k; max k = 2^RAW-1.
- HLT: IDLE, halted=1. go_in=1 gives ns=INF (PC already advanced). rdy_in is ignored in this state.
- rdy_in outside EX0/MEMW is ignored.

Decomposition:
- Package cu_param_pkg (extends mycpu_pkg usage):
  - cu_state_e;
  - opcode localparams (OP_LDI=0x10 … OP_HAL=0x7F);
  - ps encodings PS_HOLD/INC/BR/JMP;
  - FS_SHL=1110, FS_MOVB=1100, FS_ADD=0010;
  - ctrl_word_t struct with CTRL_IDLE constant.
- No sub-module; state register, cnt_r and one decoder always_comb.

Test Plan (IW=16):
- Reset, release → RST→INF→EX0. INF shows il=1, mm=1; RST shows wen=1 and all else 0.
- EX0 with ins=0x0453 (ADD, op=0x02, dst=1, a=2, b=3) → rs=12'h123, fs=0010, rw=1, ps=01, next INF.
- LD ins=0x4000|… with rdy_in low 3 cycles → EX0+3 MEMW cycles with req=1, md=01, ps=00, rw=0. Cycle with rdy=1 gives rw=1, ps=01. Repeat for ST: wen=0, rw=0 throughout.
- SHLN dst=2, k=5 → 5 consecutive cycles rw=1, fs=1110, rs=12'h220; ps=01 only on the 5th. k=0 → single no-op cycle. Reset during the 3rd shift → RST, outputs IDLE.
- BRN with n_in=1, z_in=0 → ps=10. BRZ same flags → ps=01. JMP → ps=11.
- HAL → HLT, halted=1 for 10 cycles with go_in=0. go_in=1 → INF. Opcode 0x05F → ill=1 for one cycle, ps=01.
